// File: rtl/counter_pc_sched_if.sv
// Job request / response bundle between the requesters and the PC-run scheduler.
// The scheduler takes the slave side; the job sources take the master side.
interface counter_pc_sched_if #(
    parameter int NREQ = 4,
    parameter int PCW  = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ*PCW-1:0] req_stop;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [PCW-1:0]      rsp_pc;
    logic                rsp_err;

    modport master (
        output req_valid, req_stop, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_pc, rsp_err
    );

    modport slave (
        input  req_valid, req_stop, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_pc, rsp_err
    );
endinterface

// File: rtl/counter_pc_sched.sv
// Round-robin scheduler sharing one PC run counter between NREQ job sources:
// grant, clear/launch the counter, watch done/timeout/abort, return the final PC.
module counter_pc_sched #(
    parameter int NREQ = 4,
    parameter int PCW  = 16,
    parameter int TOW  = 20
) (
    input  logic            clk,
    input  logic            rst,
    counter_pc_sched_if.slave jobs,
    input  logic [TOW-1:0]  run_limit,
    input  logic            abort,
    output logic            busy,
    output logic            ctr_clr,
    output logic [PCW-1:0]  ctr_stop,
    input  logic [PCW-1:0]  ctr_pc,
    input  logic            ctr_done
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

    state_t          state, next_state;
    logic [IDW-1:0]  rr_ptr;
    logic [TOW-1:0]  run_cnt;
    logic [IDW-1:0]  rsp_id_q;
    logic [PCW-1:0]  rsp_pc_q;
    logic            rsp_err_q;

    logic [NREQ-1:0] ready_c;
    logic            found;
    logic [IDW-1:0]  pick;
    logic [IDW:0]    cand_w;
    logic [IDW-1:0]  cand;
    logic            err_c;
    logic [PCW-1:0]  stops [NREQ];

    function automatic logic [TOW-1:0] sat_inc(input logic [TOW-1:0] v);
        return (&v) ? v : v + TOW'(1);
    endfunction

    function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] p);
        return (p == IDW'(NREQ - 1)) ? '0 : p + IDW'(1);
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_stop
        assign stops[g] = jobs.req_stop[g*PCW +: PCW];
    end

    // Rotating scan starting at rr_ptr; the first valid requester wins.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        cand_w = '0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_w = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand_w >= (IDW+1)'(NREQ))
                cand_w = cand_w - (IDW+1)'(NREQ);
            cand = cand_w[IDW-1:0];
            if (!found && jobs.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        next_state = state;
        ready_c    = '0;
        err_c      = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    ready_c[pick] = 1'b1;
                    next_state    = CLR;
                end
            end
            CLR:  next_state = RUN;
            RUN: begin
                // abort outranks a simultaneous done; done outranks the timeout
                if (abort) begin
                    next_state = RESP;
                    err_c      = 1'b1;
                end else if (ctr_done) begin
                    next_state = RESP;
                end else if (run_limit != '0 && run_cnt == run_limit - TOW'(1)) begin
                    next_state = RESP;
                    err_c      = 1'b1;
                end
            end
            RESP: begin
                if (jobs.rsp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            run_cnt   <= '0;
            ctr_clr   <= 1'b0;
            ctr_stop  <= '0;
            rsp_id_q  <= '0;
            rsp_pc_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state   <= next_state;
            ctr_clr <= (next_state == CLR);
            if (state == IDLE && found) begin
                ctr_stop <= stops[pick];
                rsp_id_q <= pick;
                rr_ptr   <= ptr_after(pick);
            end
            if (state == CLR)
                run_cnt <= '0;
            else if (state == RUN)
                run_cnt <= sat_inc(run_cnt);
            if (state == RUN && next_state == RESP) begin
                rsp_pc_q  <= ctr_pc;
                rsp_err_q <= err_c;
            end
        end
    end

    assign busy           = (state != IDLE);
    assign jobs.req_ready = ready_c;
    assign jobs.rsp_valid = (state == RESP);
    assign jobs.rsp_id    = rsp_id_q;
    assign jobs.rsp_pc    = rsp_pc_q;
    assign jobs.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_counter_pc_sched.sv
// Directed bench for counter_pc_sched with a behavioural PC run counter attached.
module tb_counter_pc_sched;
    localparam int NREQ = 4;
    localparam int PCW  = 16;
    localparam int TOW  = 20;

    logic            clk = 1'b0;
    logic            rst;
    logic [TOW-1:0]  run_limit;
    logic            abort;
    logic            busy;
    logic            ctr_clr;
    logic [PCW-1:0]  ctr_stop;
    logic [PCW-1:0]  ctr_pc;
    logic            ctr_done;

    int checks = 0;
    int errors = 0;

    counter_pc_sched_if #(.NREQ(NREQ), .PCW(PCW)) jif ();

    counter_pc_sched #(.NREQ(NREQ), .PCW(PCW), .TOW(TOW)) dut (
        .clk       (clk),
        .rst       (rst),
        .jobs      (jif.slave),
        .run_limit (run_limit),
        .abort     (abort),
        .busy      (busy),
        .ctr_clr   (ctr_clr),
        .ctr_stop  (ctr_stop),
        .ctr_pc    (ctr_pc),
        .ctr_done  (ctr_done)
    );

    always #5 clk = ~clk;

    // Shared PC counter: async clear, counts up to pc_stop and holds there.
    always_ff @(posedge clk or posedge rst or posedge ctr_clr) begin
        if (rst || ctr_clr)
            ctr_pc <= '0;
        else if (ctr_pc != ctr_stop)
            ctr_pc <= ctr_pc + 16'd1;
    end
    assign ctr_done = (ctr_pc == ctr_stop);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input logic [3:0] mask, input logic [63:0] stops,
                           input logic [19:0] limit, input logic rdy,
                           output int gid, output int lat,
                           output logic [1:0] id, output logic [15:0] pc, output logic err);
        int n;
        jif.req_valid = mask;
        jif.req_stop  = stops;
        run_limit     = limit;
        jif.rsp_ready = rdy;
        #1;
        n = 0;
        while (jif.req_ready == '0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        gid = -1;
        for (int i = 0; i < NREQ; i++)
            if (jif.req_ready[i]) gid = i;
        if (n >= 100) chk("grant_wait_bound", 32'(n), 32'd0);
        @(posedge clk); #1;
        jif.req_valid = '0;
        chk("ctr_clr_after_grant", 32'(ctr_clr), 32'd1);
        lat = 1;
        while (!jif.rsp_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        id  = jif.rsp_id;
        pc  = jif.rsp_pc;
        err = jif.rsp_err;
    endtask

    typedef struct {
        int id;
        int stop;
        int limit;
        int exp_pc;
        int exp_err;
        int exp_lat;
    } vec_t;

    vec_t vt[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid, lat;
        logic [1:0]  id;
        logic [15:0] pc;
        logic        err;
        logic [15:0] hold_pc;
        logic [1:0]  hold_id;
        logic        hold_err;
        int          rr_exp_id[5];
        int          rr_exp_pc[5];
        int          n;

        vt[0] = '{id: 1, stop: 5,   limit: 0,  exp_pc: 5, exp_err: 0, exp_lat: 8};
        vt[1] = '{id: 2, stop: 0,   limit: 0,  exp_pc: 0, exp_err: 0, exp_lat: 3};
        vt[2] = '{id: 0, stop: 100, limit: 10, exp_pc: 9, exp_err: 1, exp_lat: 12};
        vt[3] = '{id: 3, stop: 7,   limit: 10, exp_pc: 7, exp_err: 0, exp_lat: 10};
        vt[4] = '{id: 1, stop: 9,   limit: 10, exp_pc: 9, exp_err: 0, exp_lat: 12};
        vt[5] = '{id: 2, stop: 8,   limit: 1,  exp_pc: 0, exp_err: 1, exp_lat: 3};
        rr_exp_id = '{0, 1, 2, 3, 0};
        rr_exp_pc = '{2, 3, 4, 5, 2};

        rst           = 1'b1;
        abort         = 1'b0;
        run_limit     = '0;
        jif.req_valid = '0;
        jif.req_stop  = '0;
        jif.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",     32'(busy),          32'd0);
        chk("reset_rsp_valid", 32'(jif.rsp_valid), 32'd0);
        chk("reset_rsp_id",   32'(jif.rsp_id),    32'd0);
        chk("reset_rsp_pc",   32'(jif.rsp_pc),    32'd0);
        chk("reset_rsp_err",  32'(jif.rsp_err),   32'd0);
        chk("reset_ctr_clr",  32'(ctr_clr),       32'd0);
        chk("reset_ctr_stop", 32'(ctr_stop),      32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Round-robin with all four requesters asserted.
        for (int j = 0; j < 5; j++) begin
            run_job(4'hF, {16'd5, 16'd4, 16'd3, 16'd2}, 20'd0, 1'b1, gid, lat, id, pc, err);
            chk("rr_grant",  32'(gid), 32'(rr_exp_id[j]));
            chk("rr_rsp_id", 32'(id),  32'(rr_exp_id[j]));
            chk("rr_rsp_pc", 32'(pc),  32'(rr_exp_pc[j]));
            chk("rr_lat",    32'(lat), 32'(rr_exp_pc[j] + 3));
        end

        // Single jobs: latency, timeout and done-vs-timeout boundaries.
        for (int v = 0; v < 6; v++) begin
            run_job(4'(1 << vt[v].id), {4{16'(vt[v].stop)}}, 20'(vt[v].limit), 1'b1,
                    gid, lat, id, pc, err);
            chk("vec_grant",   32'(gid), 32'(vt[v].id));
            chk("vec_rsp_id",  32'(id),  32'(vt[v].id));
            chk("vec_rsp_pc",  32'(pc),  32'(vt[v].exp_pc));
            chk("vec_rsp_err", 32'(err), 32'(vt[v].exp_err));
            chk("vec_latency", 32'(lat), 32'(vt[v].exp_lat));
        end

        // Abort landing in the same cycle as ctr_done.
        @(posedge clk); #1;
        jif.req_valid = 4'b0001;
        jif.req_stop  = {4{16'd3}};
        run_limit     = '0;
        #1;
        n = 0;
        while (jif.req_ready == '0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("abort_grant", 32'(jif.req_ready), 32'd1);
        @(posedge clk); #1;
        jif.req_valid = '0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("abort_done_cycle", 32'(ctr_done), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_rsp_valid", 32'(jif.rsp_valid), 32'd1);
        chk("abort_rsp_pc",    32'(jif.rsp_pc),    32'd3);
        chk("abort_rsp_err",   32'(jif.rsp_err),   32'd1);
        @(posedge clk); #1;

        // Backpressure: response held while a new request waits.
        run_job(4'b0010, {4{16'd2}}, 20'd0, 1'b0, gid, lat, id, pc, err);
        chk("bp_rsp_pc", 32'(pc), 32'd2);
        hold_pc  = pc;
        hold_id  = id;
        hold_err = err;
        jif.req_valid = 4'b0100;
        jif.req_stop  = {4{16'd1}};
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("bp_rsp_valid", 32'(jif.rsp_valid), 32'd1);
            chk("bp_rsp_pc",    32'(jif.rsp_pc),    32'(hold_pc));
            chk("bp_rsp_id",    32'(jif.rsp_id),    32'(hold_id));
            chk("bp_rsp_err",   32'(jif.rsp_err),   32'(hold_err));
            chk("bp_req_ready", 32'(jif.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        jif.rsp_ready = 1'b1;
        #1;
        chk("bp_handshake_valid", 32'(jif.rsp_valid), 32'd1);
        @(posedge clk); #1;
        chk("bp_next_grant",     32'(jif.req_ready), 32'd4);
        chk("bp_valid_dropped",  32'(jif.rsp_valid), 32'd0);
        @(posedge clk); #1;
        jif.req_valid = '0;
        n = 0;
        while (!jif.rsp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_second_id", 32'(jif.rsp_id), 32'd2);
        chk("bp_second_pc", 32'(jif.rsp_pc), 32'd1);
        @(posedge clk); #1;

        // Reset asserted mid-RUN.
        jif.req_valid = 4'b1000;
        jif.req_stop  = {4{16'd50}};
        #1;
        n = 0;
        while (jif.req_ready == '0 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("rst_grant", 32'(jif.req_ready), 32'd8);
        @(posedge clk); #1;
        jif.req_valid = '0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_rsp_valid", 32'(jif.rsp_valid), 32'd0);
        chk("rst_rsp_pc",    32'(jif.rsp_pc),    32'd0);
        chk("rst_rsp_id",    32'(jif.rsp_id),    32'd0);
        chk("rst_ctr_clr",   32'(ctr_clr),       32'd0);
        chk("rst_ctr_stop",  32'(ctr_stop),      32'd0);
        chk("rst_ctr_pc",    32'(ctr_pc),        32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
